// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory-bus arbiter.
//
// Contents:
//   mem_src_e  - identifies which requester issued a bus transaction
//   FETCH_BE   - byte enables driven on the bus for instruction fetches
//   other_src  - returns the opposite requester (round-robin helper)
package riscv_mem_arbiter_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  localparam logic [3:0] FETCH_BE = 4'hF;

  function automatic mem_src_e other_src(input mem_src_e src);
    mem_src_e res;
    case (src)
      SRC_DATA: res = SRC_INSTR;
      default:  res = SRC_DATA;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_mem_arb_id_fifo.sv
// Source-ID FIFO: remembers, in grant order, which requester owns each
// outstanding bus transaction so responses can be routed back.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push_i      - store src_i (ignored when full)
//   src_i       - requester of the transaction just granted
//   pop_i       - discard the head entry (ignored when empty)
//   full_o      - DEPTH entries stored
//   empty_o     - no entries stored
//   head_o      - oldest stored requester
module riscv_mem_arb_id_fifo
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  mem_src_e src_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output mem_src_e head_o
);

  // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  mem_src_e             mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] res;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      res = {PTR_W{1'b0}};
    end else begin
      res = ptr + PTR_W'(1);
    end
    return res;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; push+pop together leaves occupancy unchanged.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = next_ptr(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = next_ptr(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= SRC_INSTR;
      end
    end else if (do_push) begin
      mem_q[wptr_q] <= src_i;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one OBI-style memory bus between the instruction-fetch port and the
// LSU data port. Arbitrates address phases (fixed data priority or
// round-robin), keeps a stalled address phase on the bus until it is granted,
// and routes every rvalid/rdata back to the requester that issued it.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   instr_req/addr_i           - fetch address phase; instr_gnt_o accepts it
//   instr_rvalid/rdata_o       - fetch response
//   data_req/addr/we/be/wdata_i- LSU address phase; data_gnt_o accepts it
//   data_rvalid/rdata_o        - LSU response
//   mem_req/addr/we/be/wdata_o - shared bus address phase; mem_gnt_i accepts
//   mem_rvalid/rdata_i         - shared bus response
//   busy_o                     - transactions outstanding or a request on the bus
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_PRIO       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  mem_src_e sel_src;
  mem_src_e last_q, last_d;
  mem_src_e lock_src_q, lock_src_d;
  mem_src_e fifo_head;
  logic     lock_q, lock_d;
  logic     sel_req;
  logic     fifo_full;
  logic     fifo_empty;
  logic     accept;
  logic     pop;

  // Choose the address-phase owner; a stalled request keeps ownership.
  always_comb begin
    sel_src = SRC_INSTR;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel_src = (DATA_PRIO == 1'b1) ? SRC_DATA : other_src(last_q);
    end else if (data_req_i) begin
      sel_src = SRC_DATA;
    end else begin
      sel_src = SRC_INSTR;
    end
  end

  assign sel_req = (sel_src == SRC_DATA) ? data_req_i : instr_req_i;

  // Full FIFO blocks new requests outright; a same-cycle pop does not help,
  // which keeps rvalid out of the req/gnt combinational path.
  assign mem_req_o   = sel_req & ~fifo_full;
  assign accept      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = accept & (sel_src == SRC_INSTR);
  assign data_gnt_o  = accept & (sel_src == SRC_DATA);

  // Drive the bus address phase from the selected port.
  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = FETCH_BE;
    mem_wdata_o = 32'h0000_0000;
    case (sel_src)
      SRC_DATA: begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
      default: begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = FETCH_BE;
        mem_wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Responses on an empty FIFO are dropped rather than routed.
  assign pop            = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
  assign data_rvalid_o  = pop & (fifo_head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign busy_o         = ~fifo_empty | mem_req_o;

  // Lock and round-robin history next-state.
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    last_d     = last_q;
    if (mem_req_o && !mem_gnt_i) begin
      lock_d     = 1'b1;
      lock_src_d = sel_src;
    end else if (accept) begin
      lock_d     = 1'b0;
      lock_src_d = lock_src_q;
    end else begin
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
    end
    if (accept) begin
      last_d = sel_src;
    end else begin
      last_d = last_q;
    end
  end

  // Arbitration state; last_q starts at data so instr wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      last_q     <= SRC_DATA;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
    end
  end

  riscv_mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .src_i   (sel_src),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  riscv_mem_arbiter_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_req_i  (instr_req_i),
    .instr_addr_i (instr_addr_i),
    .instr_gnt_i  (instr_gnt_o),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_i   (data_gnt_o),
    .mem_rvalid_i (mem_rvalid_i),
    .fifo_empty_i (fifo_empty)
  );

endmodule

// Protocol checker for the arbiter. Each violation is flagged by an immediate
// assertion whose action bumps a sticky counter, so violations are visible
// without stopping a run.
//   rvalid_viol_q - responses that arrived with nothing outstanding
//   proto_viol_q  - requests dropped or changed before being granted
module riscv_mem_arbiter_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        instr_req_i,
  input logic [31:0] instr_addr_i,
  input logic        instr_gnt_i,
  input logic        data_req_i,
  input logic [31:0] data_addr_i,
  input logic        data_we_i,
  input logic [3:0]  data_be_i,
  input logic [31:0] data_wdata_i,
  input logic        data_gnt_i,
  input logic        mem_rvalid_i,
  input logic        fifo_empty_i
);

  logic [7:0]  rvalid_viol_q;
  logic [7:0]  proto_viol_q;
  logic        instr_pend_q;
  logic        data_pend_q;
  logic [31:0] instr_addr_q;
  logic [68:0] data_aphase_q;

  // Remember ungranted address phases from the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_pend_q  <= 1'b0;
      data_pend_q   <= 1'b0;
      instr_addr_q  <= 32'h0000_0000;
      data_aphase_q <= 69'd0;
    end else begin
      instr_pend_q  <= instr_req_i & ~instr_gnt_i;
      data_pend_q   <= data_req_i & ~data_gnt_i;
      instr_addr_q  <= instr_addr_i;
      data_aphase_q <= {data_addr_i, data_we_i, data_be_i, data_wdata_i};
    end
  end

  // Flag response-without-request and unstable address phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_viol_q <= 8'd0;
      proto_viol_q  <= 8'd0;
    end else begin
      assert (!(mem_rvalid_i && fifo_empty_i))
        else rvalid_viol_q <= rvalid_viol_q + 8'd1;
      assert (!instr_pend_q || (instr_req_i && (instr_addr_i == instr_addr_q)))
        else proto_viol_q <= proto_viol_q + 8'd1;
      assert (!data_pend_q || (data_req_i &&
              ({data_addr_i, data_we_i, data_be_i, data_wdata_i} == data_aphase_q)))
        else proto_viol_q <= proto_viol_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter. Two instances share the stimulus:
// dut_p with data priority, dut_r with round-robin. Responses are checked
// through a scoreboard filled as rvalid stimulus is driven.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        p_instr_gnt, p_instr_rvalid, p_data_gnt, p_data_rvalid;
  logic [31:0] p_instr_rdata, p_data_rdata, p_mem_addr, p_mem_wdata;
  logic        p_mem_req, p_mem_we, p_busy;
  logic [3:0]  p_mem_be;
  logic        r_instr_gnt, r_instr_rvalid, r_data_gnt, r_data_rvalid;
  logic [31:0] r_instr_rdata, r_data_rdata, r_mem_addr, r_mem_wdata;
  logic        r_mem_req, r_mem_we, r_busy;
  logic [3:0]  r_mem_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(p_instr_gnt),
    .instr_rvalid_o(p_instr_rvalid), .instr_rdata_o(p_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(p_data_gnt),
    .data_rvalid_o(p_data_rvalid), .data_rdata_o(p_data_rdata),
    .mem_req_o(p_mem_req), .mem_addr_o(p_mem_addr), .mem_we_o(p_mem_we),
    .mem_be_o(p_mem_be), .mem_wdata_o(p_mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(p_busy)
  );

  riscv_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(r_instr_gnt),
    .instr_rvalid_o(r_instr_rvalid), .instr_rdata_o(r_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(r_data_gnt),
    .data_rvalid_o(r_data_rvalid), .data_rdata_o(r_data_rdata),
    .mem_req_o(r_mem_req), .mem_addr_o(r_mem_addr), .mem_we_o(r_mem_we),
    .mem_be_o(r_mem_be), .mem_wdata_o(r_mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(r_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard and compare a response; empty scoreboard means no rvalid.
  task automatic chk_rsp(input string tag, input logic iv, input logic dv, input logic [31:0] rd);
    rsp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".instr_rvalid"}, {31'd0, iv}, {31'd0, ~e.is_data});
      chk({tag, ".data_rvalid"},  {31'd0, dv}, {31'd0, e.is_data});
      chk({tag, ".rdata"}, rd, e.rdata);
    end else begin
      chk({tag, ".instr_rvalid_idle"}, {31'd0, iv}, 32'd0);
      chk({tag, ".data_rvalid_idle"},  {31'd0, dv}, 32'd0);
    end
  endtask

  // One cycle: drive at the falling edge, then settle before sampling.
  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic [31:0] da, input logic dwe, input logic [3:0] dbe,
                     input logic [31:0] dwd, input logic g, input logic rv,
                     input logic [31:0] rd);
    @(negedge clk);
    instr_req  = ir;  instr_addr = ia;
    data_req   = dr;  data_addr  = da;  data_we = dwe; data_be = dbe; data_wdata = dwd;
    mem_gnt    = g;   mem_rvalid = rv;  mem_rdata = rd;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_req = 1'b0; instr_addr = 32'h0; data_req = 1'b0; data_addr = 32'h0;
    data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    do_reset();

    // Reset state: nothing requested, nothing returned.
    idle();
    chk("rst.p_mem_req", {31'd0, p_mem_req}, 32'd0);
    chk("rst.p_gnt", {30'd0, p_instr_gnt, p_data_gnt}, 32'd0);
    chk("rst.p_rvalid", {30'd0, p_instr_rvalid, p_data_rvalid}, 32'd0);
    chk("rst.p_busy", {31'd0, p_busy}, 32'd0);
    chk("rst.r_req_gnt", {29'd0, r_mem_req, r_instr_gnt, r_data_gnt}, 32'd0);

    // 1: single fetch, zero-cycle routing of the response.
    drv(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t1.mem_req", {31'd0, p_mem_req}, 32'd1);
    chk("t1.mem_addr", p_mem_addr, 32'h80);
    chk("t1.mem_we_be", {27'd0, p_mem_we, p_mem_be}, 32'h0000_000F);
    chk("t1.instr_gnt", {31'd0, p_instr_gnt}, 32'd1);
    chk("t1.data_gnt", {31'd0, p_data_gnt}, 32'd0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h0000_0013});
    chk("t1.busy", {31'd0, p_busy}, 32'd1);
    chk_rsp("t1.rsp", p_instr_rvalid, p_data_rvalid, p_instr_rdata);
    idle();
    chk("t1.busy_idle", {31'd0, p_busy}, 32'd0);
    chk_rsp("t1.idle", p_instr_rvalid, p_data_rvalid, p_data_rdata);

    // 2: conflict with data priority; data first, instr next cycle.
    drv(1'b1, 32'h200, 1'b1, 32'h1000, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("t2.mem_addr", p_mem_addr, 32'h1000);
    chk("t2.mem_we", {31'd0, p_mem_we}, 32'd1);
    chk("t2.mem_be", {28'd0, p_mem_be}, 32'h3);
    chk("t2.mem_wdata", p_mem_wdata, 32'hDEAD_BEEF);
    chk("t2.gnt", {30'd0, p_instr_gnt, p_data_gnt}, 32'b01);
    drv(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t2.gnt2", {30'd0, p_instr_gnt, p_data_gnt}, 32'b10);
    chk("t2.mem_addr2", p_mem_addr, 32'h200);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11);
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h11});
    chk_rsp("t2.rsp1", p_instr_rvalid, p_data_rvalid, p_data_rdata);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h22);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h22});
    chk_rsp("t2.rsp2", p_instr_rvalid, p_data_rvalid, p_instr_rdata);

    // 3: round-robin instance alternates I,D,I,D starting with instr.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 32'h300, (k < 4), 32'h400, 1'b0, 4'hF, 32'h0, 1'b1, (k > 0), 32'h3000 + k);
      if (k > 0) exp_q.push_back('{is_data: ((k - 1) % 2 == 1), rdata: 32'h3000 + k});
      chk($sformatf("t3.instr_gnt%0d", k), {31'd0, r_instr_gnt}, {31'd0, (k % 2 == 0)});
      chk($sformatf("t3.data_gnt%0d", k), {31'd0, r_data_gnt}, {31'd0, (k % 2 == 1)});
      chk($sformatf("t3.mem_addr%0d", k), r_mem_addr, (k % 2 == 0) ? 32'h300 : 32'h400);
      chk_rsp($sformatf("t3.rsp%0d", k), r_instr_rvalid, r_data_rvalid, r_data_rdata);
    end
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h3005);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h3005});
    chk_rsp("t3.rsp_last", r_instr_rvalid, r_data_rvalid, r_instr_rdata);

    // 4: stalled fetch holds the bus even when data (higher priority) arrives.
    do_reset();
    drv(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4.c0.addr", p_mem_addr, 32'h500);
    chk("t4.c0.req_gnt", {29'd0, p_mem_req, p_instr_gnt, p_data_gnt}, 32'b100);
    for (int c = 1; c < 3; c++) begin
      drv(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 4'hF, 32'h55, 1'b0, 1'b0, 32'h0);
      chk($sformatf("t4.c%0d.addr", c), p_mem_addr, 32'h500);
      chk($sformatf("t4.c%0d.we", c), {31'd0, p_mem_we}, 32'd0);
      chk($sformatf("t4.c%0d.gnt", c), {30'd0, p_instr_gnt, p_data_gnt}, 32'b00);
    end
    drv(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 4'hF, 32'h55, 1'b1, 1'b0, 32'h0);
    chk("t4.gnt_instr", {30'd0, p_instr_gnt, p_data_gnt}, 32'b10);
    chk("t4.gnt_addr", p_mem_addr, 32'h500);
    drv(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 4'hF, 32'h55, 1'b1, 1'b0, 32'h0);
    chk("t4.gnt_data", {30'd0, p_instr_gnt, p_data_gnt}, 32'b01);
    chk("t4.data_addr", p_mem_addr, 32'h600);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h1});
    chk_rsp("t4.rsp1", p_instr_rvalid, p_data_rvalid, p_instr_rdata);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h2);
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h2});
    chk_rsp("t4.rsp2", p_instr_rvalid, p_data_rvalid, p_data_rdata);

    // 5: full FIFO gates the bus, even in the cycle that pops.
    do_reset();
    drv(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5.g1", {31'd0, p_instr_gnt}, 32'd1);
    drv(1'b1, 32'h704, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5.g2", {31'd0, p_instr_gnt}, 32'd1);
    for (int c = 0; c < 2; c++) begin
      drv(1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("t5.full%0d.req", c), {31'd0, p_mem_req}, 32'd0);
      chk($sformatf("t5.full%0d.gnt", c), {30'd0, p_instr_gnt, p_data_gnt}, 32'b00);
      chk($sformatf("t5.full%0d.busy", c), {31'd0, p_busy}, 32'd1);
    end
    drv(1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'hA1);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'hA1});
    chk("t5.pop.req", {31'd0, p_mem_req}, 32'd0);
    chk("t5.pop.gnt", {31'd0, p_data_gnt}, 32'd0);
    chk_rsp("t5.rsp1", p_instr_rvalid, p_data_rvalid, p_instr_rdata);
    drv(1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'hA2);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'hA2});
    chk("t5.after.req", {31'd0, p_mem_req}, 32'd1);
    chk("t5.after.gnt", {31'd0, p_data_gnt}, 32'd1);
    chk("t5.after.addr", p_mem_addr, 32'h800);
    chk_rsp("t5.rsp2", p_instr_rvalid, p_data_rvalid, p_instr_rdata);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA3);
    exp_q.push_back('{is_data: 1'b1, rdata: 32'hA3});
    chk_rsp("t5.rsp3", p_instr_rvalid, p_data_rvalid, p_data_rdata);
    idle();
    chk("t5.busy_idle", {31'd0, p_busy}, 32'd0);

    // 6: responses follow grant order; a spurious rvalid is flagged and dropped.
    do_reset();
    drv(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t6.gi", {30'd0, p_instr_gnt, p_data_gnt}, 32'b10);
    drv(1'b0, 32'h0, 1'b1, 32'hA00, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t6.gd", {30'd0, p_instr_gnt, p_data_gnt}, 32'b01);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA);
    exp_q.push_back('{is_data: 1'b0, rdata: 32'hA});
    chk_rsp("t6.rspA", p_instr_rvalid, p_data_rvalid, p_instr_rdata);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hB);
    exp_q.push_back('{is_data: 1'b1, rdata: 32'hB});
    chk_rsp("t6.rspB", p_instr_rvalid, p_data_rvalid, p_data_rdata);
    chk("t6.viol_before", {24'd0, dut_p.u_chk.rvalid_viol_q}, 32'd0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hC);
    chk_rsp("t6.spurious", p_instr_rvalid, p_data_rvalid, p_data_rdata);
    idle();
    chk("t6.viol_after", {24'd0, dut_p.u_chk.rvalid_viol_q}, 32'd1);
    chk("t6.busy", {31'd0, p_busy}, 32'd0);
    chk_rsp("t6.idle", p_instr_rvalid, p_data_rvalid, p_data_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
